branch_flow_ctrl: RTL and testbench

Branch prediction and control-flow recovery controller for the 5-stage pipeline. It holds a direct-mapped table of 2-bit saturating counters and predicts conditional branches in ID. It compares each EX-stage branch resolution from the branching unit against the carried prediction. It issues registered redirect and flush commands to fetch and the pipeline registers, and keeps branch and mispredict statistics for the CSR file.

---
 rtl/branch_pkg.sv | 9 +
 rtl/branch_flow_ctrl_if.sv | 22 ++
 rtl/bht_sat_counter_array.sv | 29 ++
 rtl/branch_flow_ctrl.sv | 65 ++++++
 tb/tb_branch_flow_ctrl.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared FSM states and 2-bit saturating counter encodings for branch_flow_ctrl.
package branch_pkg;
  typedef enum logic [1:0] {IDLE, ID_REDIR, EX_REDIR} state_t;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam logic [1:0] CNT_RESET = WNT;
endpackage

// File: rtl/branch_flow_ctrl_if.sv
// branch_flow_ctrl_if: ID/EX branch inputs, redirect/flush commands and statistics.
interface branch_flow_ctrl_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
  logic            id_valid, id_is_branch, id_pred_taken;
  logic [XLEN-1:0] id_pc, id_target;
  logic            ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
  logic [XLEN-1:0] ex_pc, ex_target;
  logic            redirect_valid, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [XLEN-1:0] redirect_pc;
  logic [CNT_W-1:0] branch_count, mispredict_count;
  modport master (
    output id_valid, id_is_branch, id_pc, id_target,
    output ex_valid, ex_is_branch, ex_pc, ex_target, ex_pred_taken, ex_taken,
    input  id_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
    input  branch_count, mispredict_count
  );
  modport slave (
    input  id_valid, id_is_branch, id_pc, id_target,
    input  ex_valid, ex_is_branch, ex_pc, ex_target, ex_pred_taken, ex_taken,
    output id_pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex, flush_ex_mem,
    output branch_count, mispredict_count
  );
endinterface

// File: rtl/bht_sat_counter_array.sv
// bht_sat_counter_array: direct-mapped 2-bit saturating counters, comb read, sync write.
module bht_sat_counter_array
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    rd_cnt,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);
  logic [1:0] bht_q [ENTRIES];
  logic [1:0] bht_d [ENTRIES];
  logic [1:0] cur;
  assign rd_cnt = bht_q[rd_idx];
  always_comb begin
    bht_d = bht_q;
    cur = bht_q[wr_idx];
    if (we) bht_d[wr_idx] = wr_taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) bht_q <= '{default: CNT_RESET};
    else bht_q <= bht_d;
  end
endmodule

// File: rtl/branch_flow_ctrl.sv
// branch_flow_ctrl: ID branch prediction, EX resolution and registered redirect/flush control.
module branch_flow_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  branch_flow_ctrl_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);
  state_t state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic redirect_valid_q, flush_if_id_q, flush_id_ex_q, flush_ex_mem_q;
  logic [1:0] rd_cnt;
  logic resolve, mispredict, id_detect;
  bht_sat_counter_array #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk(clk), .rst_n(rst_n),
    .rd_idx(bus.id_pc[IW+1:2]), .rd_cnt(rd_cnt),
    .we(resolve), .wr_idx(bus.ex_pc[IW+1:2]), .wr_taken(bus.ex_taken)
  );
  assign bus.id_pred_taken = bus.id_valid & bus.id_is_branch & rd_cnt[1];
  // EX stays live in ID_REDIR because the predicted branch itself is in EX then.
  always_comb begin
    resolve = (state_q != EX_REDIR) & bus.ex_valid & bus.ex_is_branch;
    mispredict = resolve & (bus.ex_pred_taken != bus.ex_taken);
    id_detect = (state_q == IDLE) & bus.id_pred_taken;
    state_d = mispredict ? EX_REDIR : id_detect ? ID_REDIR : IDLE;
    redirect_pc_d = mispredict ? (bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4))
                  : id_detect ? bus.id_target : redirect_pc_q;
    branch_count_d = branch_count_q + CNT_W'(resolve);
    mispredict_count_d = mispredict_count_q + CNT_W'(mispredict);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      redirect_pc_q <= '0;
      branch_count_q <= '0;
      mispredict_count_q <= '0;
      redirect_valid_q <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      flush_ex_mem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      redirect_pc_q <= redirect_pc_d;
      branch_count_q <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      redirect_valid_q <= state_d != IDLE;
      flush_if_id_q <= state_d != IDLE;
      flush_id_ex_q <= state_d == EX_REDIR;
      flush_ex_mem_q <= state_d == EX_REDIR;
    end
  end
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.flush_if_id = flush_if_id_q;
  assign bus.flush_id_ex = flush_id_ex_q;
  assign bus.flush_ex_mem = flush_ex_mem_q;
  assign bus.branch_count = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_flow_ctrl.sv
// tb_branch_flow_ctrl: scoreboard bench with a behavioural predictor model, directed and random stimulus.
module tb_branch_flow_ctrl;
  localparam int CW = 4;
  typedef struct packed {
    logic rv, fi, fd, fe;
    logic [31:0] pc;
    logic [CW-1:0] bc, mc;
  } exp_t;
  logic clk = 0, rst_n = 0;
  int tests = 0, fails = 0;
  exp_t q[$];
  int m_bht[16];
  int m_cmd = 0;
  logic [31:0] m_rpc = 0;
  int unsigned m_bc = 0, m_mc = 0;
  branch_flow_ctrl_if #(.XLEN(32), .CNT_W(CW)) bus ();
  branch_flow_ctrl #(.XLEN(32), .BHT_ENTRIES(16), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = '{bus.redirect_valid, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem,
            bus.redirect_pc, bus.branch_count, bus.mispredict_count};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs: got rv=%b fl=%b%b%b pc=%h bc=%0d mc=%0d, expected rv=%b fl=%b%b%b pc=%h bc=%0d mc=%0d",
          a.rv, a.fi, a.fd, a.fe, a.pc, a.bc, a.mc, e.rv, e.fi, e.fd, e.fe, e.pc, e.bc, e.mc);
      end
    end
  end

  task automatic step(input logic rn, iv, ib, input logic [31:0] ipc, itg,
                      input logic ev, eb, input logic [31:0] epc, etg, input logic ep, et);
    logic pred, mis;
    exp_t e;
    rst_n = rn;
    bus.id_valid = iv; bus.id_is_branch = ib; bus.id_pc = ipc; bus.id_target = itg;
    bus.ex_valid = ev; bus.ex_is_branch = eb; bus.ex_pc = epc; bus.ex_target = etg;
    bus.ex_pred_taken = ep; bus.ex_taken = et;
    #1;
    if (!rn) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_cmd = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    end else begin
      pred = iv && ib && m_bht[idx(ipc)] >= 2;
      tests++;
      if (bus.id_pred_taken !== pred) begin
        fails++;
        $display("FAIL id_pred_taken pc=%h: got %b expected %b", ipc, bus.id_pred_taken, pred);
      end
      mis = 0;
      if (m_cmd != 2 && ev && eb) begin
        m_bc++;
        m_bht[idx(epc)] = et ? (m_bht[idx(epc)] == 3 ? 3 : m_bht[idx(epc)] + 1)
                             : (m_bht[idx(epc)] == 0 ? 0 : m_bht[idx(epc)] - 1);
        if (ep != et) begin
          mis = 1; m_mc++;
          m_rpc = et ? etg : epc + 4;
        end
      end
      if (mis) m_cmd = 2;
      else if (m_cmd == 0 && pred) begin m_cmd = 1; m_rpc = itg; end
      else m_cmd = 0;
    end
    e = '{m_cmd != 0, m_cmd != 0, m_cmd == 2, m_cmd == 2, m_rpc, CW'(m_bc), CW'(m_mc)};
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(); step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic id_br(input logic [31:0] pc, tg); step(1, 1, 1, pc, tg, 0, 0, 0, 0, 0, 0); endtask
  task automatic ex_br(input logic [31:0] pc, tg, input logic p, t); step(1, 0, 0, 0, 0, 1, 1, pc, tg, p, t); endtask

  task automatic check_bht(input string tag);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (int'(dut.u_bht.bht_q[i]) != m_bht[i]) begin
        fails++;
        $display("FAIL bht %s [%0d]: got %0d expected %0d", tag, i, dut.u_bht.bht_q[i], m_bht[i]);
      end
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_bht("reset");
    id_br(32'h100, 32'h80);
    ex_br(32'h100, 32'h80, 0, 0);
    idle();
    ex_br(32'h100, 32'h80, 0, 1);
    idle();
    id_br(32'h100, 32'h80);
    ex_br(32'h100, 32'h80, 1, 1);
    idle();
    check_bht("train");
    ex_br(32'h200, 32'h300, 1, 0);
    idle();
    step(1, 1, 1, 32'h100, 32'h80, 1, 1, 32'h344, 32'h900, 1, 0);
    idle();
    check_bht("same_cycle");
    id_br(32'h100, 32'h80);
    ex_br(32'h348, 32'h500, 0, 1);
    ex_br(32'h100, 32'h80, 0, 1);
    step(1, 1, 1, 32'h100, 32'h80, 1, 1, 32'h104, 32'h40, 1, 0);
    idle();
    check_bht("ex_redir_ignore");
    ex_br(32'h400, 32'h444, 0, 1);
    step(0, 1, 1, 32'h100, 32'h80, 1, 1, 32'h100, 32'h80, 0, 1);
    idle();
    check_bht("reset_ex_redir");
    for (int i = 0; i < 16; i++) begin
      ex_br(32'h600, 32'h700, 0, 1);
      idle();
    end
    tests++;
    if (bus.mispredict_count !== '0) begin
      fails++;
      $display("FAIL wrap: got %0d expected 0", bus.mispredict_count);
    end
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
           1'($urandom), 1'($urandom));
    end
    check_bht("random");
    idle();
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
